// File: rtl/bw_seq_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bw_seq_mult_ctrl_if
//  Description : Handshake bundle for the sequential Baugh-Wooley multiplier.
//                master = producer/consumer side, slave = multiplier side.
//                Signals:
//                  start_valid/start_ready : operand handshake
//                  a, b                    : signed operands (N bits)
//                  sign_sel                : signed/unsigned select, only
//                                            present with BW_SIGN_SEL_EN
//                  res_valid/res_ready     : result handshake
//                  product                 : 2N-bit result
//                  busy                    : multiplier not idle
//                Optional macro: BW_SIGN_SEL_EN
//  Revision    : 1.0 - initial release
// ============================================================================
interface bw_seq_mult_ctrl_if #(
  parameter int N = 8
);
  logic           start_valid;
  logic           start_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           res_valid;
  logic           res_ready;
  logic [2*N-1:0] product;
  logic           busy;
`ifdef BW_SIGN_SEL_EN
  logic           sign_sel;

  modport master (
    output start_valid, a, b, sign_sel, res_ready,
    input  start_ready, res_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, sign_sel, res_ready,
    output start_ready, res_valid, product, busy
  );
`else
  modport master (
    output start_valid, a, b, res_ready,
    input  start_ready, res_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, res_ready,
    output start_ready, res_valid, product, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/bw_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bw_seq_mult_ctrl
//  Description : Sequential two's-complement multiplier. One N-bit
//                Baugh-Wooley partial-product row is added into a 2N-bit
//                accumulator per clock, giving the product N cycles after the
//                start handshake.
//                Ports:
//                  clk   : rising-edge clock
//                  rst_n : asynchronous active-low reset
//                  bus   : bw_seq_mult_ctrl_if.slave (operand/result
//                          handshakes, product, busy)
//                Optional macro: BW_SIGN_SEL_EN adds bus.sign_sel
//                  (1 = signed Baugh-Wooley, 0 = unsigned). Without it every
//                  operation is signed.
//  Revision    : 1.0 - initial release
// ============================================================================
module bw_seq_mult_ctrl #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bw_seq_mult_ctrl_if.slave  bus
);

  localparam int c_cnt_w = $clog2(N);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);
  localparam logic [2*N-1:0] c_one = (2*N)'(1);
  // Baugh-Wooley correction: (1<<N) + (1<<(2N-1)), wrapped to 2N bits.
  localparam logic [2*N-1:0] c_bw_const = (c_one << N) | (c_one << (2*N - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic               r_signed;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2*N-1:0]     r_acc;
  logic               r_start_ready;
  logic               r_res_valid;
  logic               r_busy;

  logic               w_sign_in;
  logic [N-1:0]       w_pp;
  logic [N-1:0]       w_row;
  logic [2*N-1:0]     w_addend;

`ifdef BW_SIGN_SEL_EN
  assign w_sign_in = bus.sign_sel;
`else
  assign w_sign_in = 1'b1;
`endif

  // Current partial-product row. In signed mode the sign column of rows
  // 0..N-2 is inverted, and in the last row every column except the sign
  // column is inverted; the constant preloaded into the accumulator
  // cancels the inversions.
  always_comb begin
    w_pp  = r_a & {N{r_b[r_cnt]}};
    w_row = w_pp;
    if (r_signed) begin
      if (r_cnt == c_last) begin
        w_row        = ~w_pp;
        w_row[N-1]   = w_pp[N-1];
      end else begin
        w_row[N-1]   = ~w_pp[N-1];
      end
    end
  end

  assign w_addend = {{N{1'b0}}, w_row} << r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_signed      <= 1'b0;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_start_ready <= 1'b0;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // r_start_ready is low only on the first cycle after reset, so no
          // operand is taken before the block reports itself ready.
          if (bus.start_valid && r_start_ready) begin
            r_a           <= bus.a;
            r_b           <= bus.b;
            r_signed      <= w_sign_in;
            r_cnt         <= '0;
            r_acc         <= w_sign_in ? c_bw_const : '0;
            r_state       <= S_RUN;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end else begin
            r_start_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_addend;
          if (r_cnt == c_last) begin
            // Counter parks at N-1 rather than wrapping.
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_state       <= S_IDLE;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_res_valid   <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.busy        = r_busy;
  assign bus.product     = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_bw_seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bw_seq_mult_ctrl
//  Description : Scoreboard bench for bw_seq_mult_ctrl (N = 8). The driver
//                pushes the expected product and accept cycle on every start
//                handshake; the monitor pops on every result handshake.
//                Optional macro: BW_SIGN_SEL_EN enables the unsigned-mode
//                vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bw_seq_mult_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bw_seq_mult_ctrl_if #(.N(N)) bus ();

  bw_seq_mult_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] exp;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_acc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: checks every result handshake, latency and DONE stability.
  logic        prev_valid = 1'b0;
  logic [15:0] held       = '0;
  int          rise_cyc   = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.res_valid) begin
        if (!prev_valid) begin
          rise_cyc = cyc;
          held     = bus.product;
        end else begin
          check("product_stable", 32'(bus.product), 32'(held));
        end
        check("start_ready_low_in_done", 32'(bus.start_ready), 32'd0);
        if (bus.res_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%0h, required no result", bus.product);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", 32'(bus.product), 32'(e.exp));
            check("latency", 32'(rise_cyc - e.acc_cyc), 32'd8);
          end
        end
      end
      prev_valid = bus.res_valid;
    end
  end

  logic tb_sign_sel = 1'b1;
`ifdef BW_SIGN_SEL_EN
  assign bus.sign_sel = tb_sign_sel;
`endif

  // Called right after a posedge (+#1). Returns at accept edge + #1.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp,
                       input bit hold, input bit scramble, input bit gap_chk, input bit sgn);
    int t;
    t = 0;
    bus.a           = ia;
    bus.b           = ib;
    tb_sign_sel     = sgn;
    bus.start_valid = 1'b1;
    @(negedge clk);
    while (!bus.start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.start_ready) begin
      timeout_fail("accept_wait");
      bus.start_valid = 1'b0;
      return;
    end
    sb.push_back('{exp, cyc + 1});
    if (gap_chk) check("issue_interval", 32'(cyc + 1 - last_acc), 32'd10);
    last_acc = cyc + 1;
    @(posedge clk); #1;
    if (!hold) bus.start_valid = 1'b0;
    if (scramble) begin
      repeat (N) begin
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || bus.busy) timeout_fail("drain_wait");
    @(posedge clk); #1;
  endtask

  logic [7:0]  b2b_a [6] = '{8'd12, 8'hF9, 8'd100, 8'h80, 8'd1,   8'd2};
  logic [7:0]  b2b_b [6] = '{8'd12, 8'd9,  8'h9C,  8'd127, 8'h80, 8'd3};
  logic [15:0] b2b_p [6] = '{16'h0090, 16'hFFC1, 16'hD8F0, 16'hC080, 16'hFF80, 16'h0006};

  initial begin
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    bus.a           = '0;
    bus.b           = '0;
    #12;
    check("rst_start_ready", 32'(bus.start_ready), 32'd0);
    check("rst_res_valid",   32'(bus.res_valid),   32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_product",     32'(bus.product),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("post_rst_busy",        32'(bus.busy),        32'd0);

    // Signed corner cases
    issue(8'h80, 8'h80, 16'h4000, 0, 0, 0, 1); drain();
    issue(8'hFF, 8'h01, 16'hFFFF, 0, 0, 0, 1); drain();
    issue(8'h7F, 8'h80, 16'hC080, 0, 0, 0, 1); drain();
    issue(8'h00, 8'hB3, 16'h0000, 0, 0, 0, 1); drain();

    // Operand isolation during RUN
    issue(8'd25, 8'hFD, 16'hFFB5, 0, 1, 0, 1); drain();

    // Back-pressure in DONE with start_valid pulses
    bus.res_ready = 1'b0;
    issue(8'hFB, 8'd7, 16'hFFDD, 0, 0, 0, 1);
    begin
      int t;
      t = 0;
      while (!bus.res_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.res_valid) timeout_fail("res_valid_wait");
    end
    repeat (5) begin
      bus.start_valid = ~bus.start_valid;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(negedge clk);
      check("res_valid_held", 32'(bus.res_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    drain();

    // Asynchronous reset mid-RUN at iteration 4
    issue(8'd100, 8'd3, 16'h012C, 0, 0, 0, 1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_start_ready", 32'(bus.start_ready), 32'd0);
    check("midrun_rst_res_valid",   32'(bus.res_valid),   32'd0);
    check("midrun_rst_busy",        32'(bus.busy),        32'd0);
    check("midrun_rst_product",     32'(bus.product),     32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'd3, 8'd5, 16'h000F, 0, 0, 0, 1); drain();

    // Back-to-back stream: directed then random against a signed model
    for (int i = 0; i < 6; i++)
      issue(b2b_a[i], b2b_b[i], b2b_p[i], 1, 0, (i > 0), 1);
    for (int i = 0; i < 16; i++) begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rp;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = 16'($signed(ra) * $signed(rb));
      issue(ra, rb, rp, 1, 0, 1, 1);
    end
    bus.start_valid = 1'b0;
    drain();

`ifdef BW_SIGN_SEL_EN
    issue(8'hFF, 8'hFF, 16'hFE01, 0, 0, 0, 0); drain();
    issue(8'hFF, 8'hFF, 16'h0001, 0, 0, 0, 1); drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
